param_bus_mux: RTL and testbench
================================

Name: param_bus_mux

Overview:
- Parametrised datapath bus multiplexer and controller for the CPU datapath.
- Generalises the fixed 24-source, select-coded bus mux in three ways:
  - configurable source count and width;
  - sources chosen directly from the control unit's one-hot "<reg>out" drive enables;
  - added sequential features: optional output register, bus-keeper hold, multi-driver conflict detection and a transfer counter.
- Sits between the register file / special registers (HI, LO, Z, PC, MDR, port, C) and all bus consumers.

Parameters:
- WIDTH, 32: bus data width in bits.
- NUM_SRC, 24: number of bus sources. Legal range is 2..64.
- SEL_W, 5: width of the encoded source index. Must satisfy 2**SEL_W >= NUM_SRC.
- REGISTERED, 1: 1 = bus output registered (1-cycle latency); 0 = combinational data path.
- CNT_W, 16: width of the transfer counter.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- src_data  in  NUM_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- src_out_en  in  NUM_SRC  drive enables; bit i requests that source i drive the bus. Expected one-hot or zero.
- conflict_clr  in  1  clears the sticky conflict flag.
- bus_out  out  WIDTH  bus value seen by consumers.
- bus_sel  out  SEL_W  index of the source currently on the bus.
- bus_valid  out  1  bus_out reflects a source driven this transfer.
- conflict  out  1  sticky flag: more than one enable was asserted in some cycle.
- xfer_count  out  CNT_W  count of cycles with at least one enable asserted; saturating.

Behaviour:
- Reset (clr=1 at a rising edge), all state cleared:
  - bus_out=0, bus_sel=0, bus_valid=0, conflict=0, xfer_count=0;
  - hold register = 0.
  - clr has priority over every other input, including a transfer in progress.
- Selection:
  - win = lowest index i with src_out_en[i]=1 (priority encoder).
  - any_en = OR of src_out_en.
  - multi = 1 when two or more enable bits are set.
- Hold register (both modes): on each clock edge with any_en=1, it loads src_data[win].
- REGISTERED=1:
  - When any_en=1 at edge N, from edge N onward: bus_out = src_data[win], bus_sel = win, bus_valid = 1.
  - When any_en=0 at an edge: bus_out and bus_sel keep their previous values (bus-keeper), bus_valid = 0.
  - Latency from enable to bus_out is 1 cycle.
- REGISTERED=0:
  - any_en=1: bus_out = src_data[win] and bus_sel = win, combinationally in the same cycle; bus_valid = 1.
  - any_en=0: bus_out = hold register, bus_sel = last registered win, bus_valid = 0.
  - Never X, never high-Z.
- Conflict:
  - multi=1 at an edge sets conflict=1 from the next cycle.
  - The bus still carries the lowest-index source.
  - conflict_clr=1 at an edge clears the flag unless multi=1 at the same edge; set wins.
- Counter:
  - xfer_count increments by 1 at each edge with any_en=1, including conflict cycles.
  - Saturates at 2**CNT_W-1; no wrap.
  - Cleared only by clr.
- Index range:
  - Enable bits at or above NUM_SRC do not exist.
  - bus_sel never exceeds NUM_SRC-1.
- Out-of-range parameters (NUM_SRC<2 or 2**SEL_W<NUM_SRC): elaboration-time error.

Test Plan:
1. Reset and first drive (REGISTERED=1):
   - Stimulus: clr for 2 cycles; src_data[3]=0xDEADBEEF; src_out_en=1<<3 for 1 cycle.
   - Required: bus_out=0xDEADBEEF, bus_sel=3, bus_valid=1 one edge later; xfer_count=1.
2. Bus-keeper:
   - Stimulus: after scenario 1, src_out_en=0 for 3 cycles while src_data[3] changes to 0x12345678.
   - Required: bus_out stays 0xDEADBEEF, bus_valid=0, xfer_count stays 1.
3. Conflict:
   - Stimulus: src_out_en has bits 5 and 20 set; src_data[5]=0xAAAA0005, src_data[20]=0x55550014.
   - Required: bus_out=0xAAAA0005, bus_sel=5, conflict=1, held after enables drop.
   - Then: conflict_clr pulse with no enables -> conflict=0.
   - Then: conflict_clr in the same cycle as a double enable -> conflict stays 1.
4. Combinational mode (REGISTERED=0, WIDTH=16, NUM_SRC=4, SEL_W=2):
   - Stimulus: src_out_en=4'b0100 with src_data[2]=0xBEEF.
   - Required: bus_out=0xBEEF in the same cycle; after enables drop, bus_out stays 0xBEEF with bus_valid=0.
5. Saturation (CNT_W=4):
   - Stimulus: 20 consecutive enabled cycles.
   - Required: xfer_count reaches 15 and holds at 15.
6. Reset mid-operation:
   - Stimulus: assert clr while src_out_en=1<<23 and conflict=1.
   - Required: next cycle all outputs are 0; the following idle cycle has bus_out=0.

Source files
------------

// File: rtl/param_bus_mux.sv
// Parametrised datapath bus mux: lowest-index drive enable wins the bus.
// Adds bus-keeper hold, optional output register, sticky conflict flag and transfer counter.
module param_bus_mux #(
  parameter int WIDTH      = 32,
  parameter int NUM_SRC    = 24,
  parameter int SEL_W      = 5,
  parameter bit REGISTERED = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_out_en,
  input  logic                     conflict_clr,
  output logic [WIDTH-1:0]         bus_out,
  output logic [SEL_W-1:0]         bus_sel,
  output logic                     bus_valid,
  output logic                     conflict,
  output logic [CNT_W-1:0]         xfer_count
);

  generate
    if (NUM_SRC < 2 || NUM_SRC > 64 || (2 ** SEL_W) < NUM_SRC) begin : g_bad_param
      $error("param_bus_mux: illegal NUM_SRC/SEL_W combination");
    end
  endgenerate

  localparam logic [NUM_SRC-1:0] EN_ONE = NUM_SRC'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] win_data;
  logic             any_en;
  logic             multi;

  logic [WIDTH-1:0] hold_q;
  logic [SEL_W-1:0] sel_q;
  logic             conflict_q;
  logic [CNT_W-1:0] cnt_q;

  // Scan from the top so the lowest enabled index is written last.
  always_comb begin
    win      = '0;
    win_data = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_out_en[i]) begin
        win      = SEL_W'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any_en = |src_out_en;
  assign multi  = |(src_out_en & (src_out_en - EN_ONE));

  always_ff @(posedge clk) begin
    if (clr) begin
      hold_q <= '0;
      sel_q  <= '0;
    end else if (any_en) begin
      hold_q <= win_data;
      sel_q  <= win;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      conflict_q <= 1'b0;
    end else if (multi) begin
      conflict_q <= 1'b1;
    end else if (conflict_clr) begin
      conflict_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (any_en && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Registered mode: the hold register doubles as the output register.
  generate
    if (REGISTERED) begin : g_reg
      logic valid_q;

      always_ff @(posedge clk) begin
        if (clr) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= any_en;
        end
      end

      assign bus_out   = hold_q;
      assign bus_sel   = sel_q;
      assign bus_valid = valid_q;
    end else begin : g_comb
      assign bus_out   = any_en ? win_data : hold_q;
      assign bus_sel   = any_en ? win : sel_q;
      assign bus_valid = any_en;
    end
  endgenerate

  assign conflict   = conflict_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_param_bus_mux.sv
// Scoreboard bench for param_bus_mux: registered 24x32 instance and combinational 4x16 instance.
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_param_bus_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr = 1'b0;
  logic        cclr = 1'b0;
  logic [23:0] en_a = '0;
  logic [3:0]  en_b = '0;

  logic [31:0] da [24];
  logic [31:0] na [24];
  logic [15:0] db [4];
  logic [15:0] nb [4];

  logic [24*32-1:0] sd_a;
  logic [4*16-1:0]  sd_b;

  always_comb begin
    sd_a = '0;
    for (int i = 0; i < 24; i++) sd_a[i*32 +: 32] = da[i];
  end

  always_comb begin
    sd_b = '0;
    for (int i = 0; i < 4; i++) sd_b[i*16 +: 16] = db[i];
  end

  logic [31:0] a_bus;
  logic [4:0]  a_sel;
  logic        a_val, a_conf;
  logic [15:0] a_cnt;
  logic [15:0] b_bus;
  logic [1:0]  b_sel;
  logic        b_val, b_conf;
  logic [3:0]  b_cnt;

  param_bus_mux #(
    .WIDTH(32), .NUM_SRC(24), .SEL_W(5), .REGISTERED(1'b1), .CNT_W(16)
  ) u_a (
    .clk(clk), .clr(clr), .src_data(sd_a), .src_out_en(en_a),
    .conflict_clr(cclr), .bus_out(a_bus), .bus_sel(a_sel),
    .bus_valid(a_val), .conflict(a_conf), .xfer_count(a_cnt)
  );

  param_bus_mux #(
    .WIDTH(16), .NUM_SRC(4), .SEL_W(2), .REGISTERED(1'b0), .CNT_W(4)
  ) u_b (
    .clk(clk), .clr(clr), .src_data(sd_b), .src_out_en(en_b),
    .conflict_clr(cclr), .bus_out(b_bus), .bus_sel(b_sel),
    .bus_valid(b_val), .conflict(b_conf), .xfer_count(b_cnt)
  );

  typedef struct {
    bit          chk;
    logic [31:0] ab;
    logic [4:0]  as;
    logic        av, ac;
    logic [15:0] acnt;
    logic [15:0] bb;
    logic [1:0]  bs;
    logic        bv, bc;
    logic [3:0]  bcnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit known = 1'b0;

  // Reference state: last value latched onto the bus, its index, flags.
  logic [31:0] m_hold [2];
  int          m_sel  [2];
  bit          m_val  [2];
  bit          m_conf [2];
  int          m_cnt  [2];

  function automatic int lowest(logic [23:0] en);
    for (int i = 0; i < 24; i++) if (en[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(int k, bit c, bit cc, logic [23:0] en,
                            logic [31:0] d [24], int cmax);
    int w;
    w = lowest(en);
    if (c) begin
      m_hold[k] = 0; m_sel[k] = 0; m_val[k] = 0;
      m_conf[k] = 0; m_cnt[k] = 0;
    end else begin
      if (w >= 0) begin
        m_hold[k] = d[w];
        m_sel[k]  = w;
        m_val[k]  = 1;
        if (m_cnt[k] < cmax) m_cnt[k]++;
      end else begin
        m_val[k] = 0;
      end
      if ($countones(en) > 1) m_conf[k] = 1;
      else if (cc) m_conf[k] = 0;
    end
  endtask

  task automatic step(bit c, bit cc, logic [23:0] ea, logic [3:0] eb);
    exp_t e;
    int wb;
    logic [31:0] xb [24];
    @(posedge clk);
    #2;
    clr = c; cclr = cc; en_a = ea; en_b = eb;
    for (int i = 0; i < 24; i++) da[i] = na[i];
    for (int i = 0; i < 4; i++) db[i] = nb[i];
    for (int i = 0; i < 24; i++) xb[i] = (i < 4) ? {16'h0, nb[i]} : 32'h0;
    e.chk  = known;
    e.ab   = m_hold[0];
    e.as   = 5'(m_sel[0]);
    e.av   = m_val[0];
    e.ac   = m_conf[0];
    e.acnt = 16'(m_cnt[0]);
    wb = lowest({20'h0, eb});
    if (wb >= 0) begin
      e.bb = nb[wb]; e.bs = 2'(wb); e.bv = 1'b1;
    end else begin
      e.bb = m_hold[1][15:0]; e.bs = 2'(m_sel[1]); e.bv = 1'b0;
    end
    e.bc   = m_conf[1];
    e.bcnt = 4'(m_cnt[1]);
    q.push_back(e);
    model_edge(0, c, cc, ea, na, 65535);
    model_edge(1, c, cc, {20'h0, eb}, xb, 15);
    if (c) known = 1'b1;
  endtask

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        cmp("a_bus_out", a_bus, e.ab);
        cmp("a_bus_sel", {27'h0, a_sel}, {27'h0, e.as});
        cmp("a_bus_valid", {31'h0, a_val}, {31'h0, e.av});
        cmp("a_conflict", {31'h0, a_conf}, {31'h0, e.ac});
        cmp("a_xfer_count", {16'h0, a_cnt}, {16'h0, e.acnt});
        cmp("b_bus_out", {16'h0, b_bus}, {16'h0, e.bb});
        cmp("b_bus_sel", {30'h0, b_sel}, {30'h0, e.bs});
        cmp("b_bus_valid", {31'h0, b_val}, {31'h0, e.bv});
        cmp("b_conflict", {31'h0, b_conf}, {31'h0, e.bc});
        cmp("b_xfer_count", {28'h0, b_cnt}, {28'h0, e.bcnt});
      end
    end
  end

  function automatic logic [23:0] rand_en(int n);
    int r;
    logic [23:0] v;
    r = $urandom_range(9);
    v = '0;
    if (r >= 4) v[$urandom_range(n - 1)] = 1'b1;
    if (r >= 8) v[$urandom_range(n - 1)] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [23:0] two;
    logic [23:0] ra;
    logic [23:0] rb;
    bit rc;
    for (int i = 0; i < 24; i++) begin
      na[i] = $urandom; da[i] = na[i];
    end
    for (int i = 0; i < 4; i++) begin
      nb[i] = 16'($urandom); db[i] = nb[i];
    end
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_sel[k] = 0; m_val[k] = 0; m_conf[k] = 0; m_cnt[k] = 0;
    end

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    na[3] = 32'hDEADBEEF;
    step(0, 0, 24'h1 << 3, 0);
    na[3] = 32'h12345678;
    repeat (3) step(0, 0, 0, 0);

    na[5] = 32'hAAAA0005;
    na[20] = 32'h55550014;
    two = (24'h1 << 5) | (24'h1 << 20);
    step(0, 0, two, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, two, 0);
    repeat (2) step(0, 0, 0, 0);

    nb[2] = 16'hBEEF;
    step(0, 0, 0, 4'b0100);
    nb[2] = 16'h1111;
    repeat (2) step(0, 0, 0, 0);

    for (int i = 0; i < 20; i++) step(0, 0, 0, 4'(24'h1 << $urandom_range(3)));
    step(0, 0, 0, 0);

    step(0, 0, 24'h1 << 23, 0);
    step(1, 0, 24'h1 << 23, 0);
    repeat (2) step(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      na[$urandom_range(23)] = $urandom;
      nb[$urandom_range(3)] = 16'($urandom);
      rc = ($urandom_range(49) == 0);
      ra = rand_en(24);
      rb = rc ? 24'h0 : rand_en(4);
      step(rc, ($urandom_range(3) == 0), ra, rb[3:0]);
    end

    repeat (2) step(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
